// File: rtl/uart_tx_fifo_param_pkg.sv
// Shared types and constants for the parametrised UART transmitter.
// Holds the FSM state encoding, the parity mode codes and the parity helper.
package uart_tx_fifo_param_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } uart_state_e;

    localparam int unsigned PARITY_NONE = 0;
    localparam int unsigned PARITY_ODD  = 1;
    localparam int unsigned PARITY_EVEN = 2;

    // Zero-extended data leaves the XOR unchanged, so 5..8 bit words share this.
    function automatic logic parity_bit(input logic [7:0] data, input int unsigned mode);
        return (mode == PARITY_ODD) ? ~^data : ^data;
    endfunction

endpackage

// File: rtl/uart_tx_fifo_param_if.sv
// Valid/ready byte-producer handshake into the UART transmitter FIFO.
interface uart_tx_fifo_param_if #(
    parameter int unsigned DATA_BITS = 8
);
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;

    modport master (output tx_data, output tx_valid, input  tx_ready);
    modport slave  (input  tx_data, input  tx_valid, output tx_ready);
endinterface

// File: rtl/uart_tx_fifo_param_fifo.sv
// Small synchronous FIFO with a registered read port (data valid the cycle after pop).
module uart_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);
    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W:0]   level_q;
    logic [WIDTH-1:0] data_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (level_q == (PTR_W + 1)'(DEPTH));
    assign empty_o = (level_q == '0);
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign data_o  = data_q;
    assign level_o = level_q;

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            data_q   <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
                data_q   <= mem_q[rd_ptr_q];
            end
            case ({do_push, do_pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_fifo_param.sv
// Parametrised UART transmitter: baud divider, 5-8 data bits, optional parity,
// 1-2 stop bits, fed from a small FIFO behind a valid/ready handshake.
module uart_tx_fifo_param
    import uart_tx_fifo_param_pkg::*;
#(
    parameter int unsigned CLK_DIV    = 104,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY     = 0,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    uart_tx_fifo_param_if.slave           tx_if,
    output logic                          uart_tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    if (CLK_DIV < 2 || DATA_BITS < 5 || DATA_BITS > 8 || PARITY > 2 ||
        STOP_BITS < 1 || STOP_BITS > 2 || FIFO_DEPTH < 2 ||
        (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_param_check
        $error("uart_tx_fifo_param: illegal parameter combination");
    end

    localparam int unsigned        BAUD_W    = $clog2(CLK_DIV);
    localparam logic [BAUD_W-1:0]  BAUD_LAST = BAUD_W'(CLK_DIV - 1);

    uart_state_e          state_q, state_d;
    logic [BAUD_W-1:0]    baud_q, baud_d;
    logic [2:0]           bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_q, par_d;
    logic                 tx_q, tx_d;

    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 fifo_pop;
    logic [DATA_BITS-1:0] fifo_data;
    logic                 baud_end;

    uart_sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (tx_if.tx_valid),
        .data_i  (tx_if.tx_data),
        .pop_i   (fifo_pop),
        .data_o  (fifo_data),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (fifo_level)
    );

    assign tx_if.tx_ready = ~fifo_full;
    assign uart_tx        = tx_q;
    assign busy           = (state_q != ST_IDLE) | (fifo_level != '0);
    assign baud_end       = (baud_q == BAUD_LAST);

    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        par_d    = par_q;
        fifo_pop = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                baud_d = '0;
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    state_d  = ST_START;
                end
            end
            ST_START: begin
                // The popped word lands in the FIFO read register one cycle
                // after the pop, i.e. on the first START cycle.
                if (baud_q == '0) begin
                    shift_d = fifo_data;
                    par_d   = parity_bit(8'(fifo_data), PARITY);
                end
                if (baud_end) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = ST_DATA;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            ST_DATA: begin
                if (baud_end) begin
                    baud_d  = '0;
                    shift_d = shift_q >> 1;
                    if (bit_q == 3'(DATA_BITS - 1)) begin
                        bit_d   = '0;
                        state_d = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            ST_PARITY: begin
                if (baud_end) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = ST_STOP;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            ST_STOP: begin
                if (baud_end) begin
                    baud_d = '0;
                    if (bit_q == 3'(STOP_BITS - 1)) begin
                        bit_d = '0;
                        if (!fifo_empty) begin
                            fifo_pop = 1'b1;
                            state_d  = ST_START;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Line level follows the current state one cycle later, uniformly for every bit.
    always_comb begin
        tx_d = 1'b1;
        unique case (state_q)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = shift_q[0];
            ST_PARITY: tx_d = par_q;
            default:   tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo_param.sv
// Bench for uart_tx_fifo_param: three format variants, a line decoder that
// checks every bit centre against frames built from the accepted words.
module tb_uart_tx_fifo_param;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    uart_tx_fifo_param_if #(.DATA_BITS(8)) if0 ();
    uart_tx_fifo_param_if #(.DATA_BITS(8)) if1 ();
    uart_tx_fifo_param_if #(.DATA_BITS(7)) if2 ();

    logic       tx0, tx1, tx2;
    logic       busy0, busy1, busy2;
    logic [2:0] lvl0, lvl1, lvl2;

    // u0: 8N1 /4, u1: 8E1 /4, u2: 7O2 /3
    uart_tx_fifo_param #(.CLK_DIV(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u0 (
        .clk(clk), .reset(reset), .tx_if(if0), .uart_tx(tx0), .busy(busy0), .fifo_level(lvl0));
    uart_tx_fifo_param #(.CLK_DIV(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) u1 (
        .clk(clk), .reset(reset), .tx_if(if1), .uart_tx(tx1), .busy(busy1), .fifo_level(lvl1));
    uart_tx_fifo_param #(.CLK_DIV(3), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(4)) u2 (
        .clk(clk), .reset(reset), .tx_if(if2), .uart_tx(tx2), .busy(busy2), .fifo_level(lvl2));

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic int cdiv(int i);  return (i == 2) ? 3 : 4; endfunction
    function automatic int nbits(int i); return (i == 2) ? 7 : 8; endfunction
    function automatic int pmode(int i); return (i == 0) ? 0 : ((i == 1) ? 2 : 1); endfunction
    function automatic int nstop(int i); return (i == 2) ? 2 : 1; endfunction
    function automatic int flen(int i);
        return 1 + nbits(i) + ((pmode(i) != 0) ? 1 : 0) + nstop(i);
    endfunction
    function automatic logic [7:0] wmask(int i); return (i == 2) ? 8'h7F : 8'hFF; endfunction

    function automatic logic get_line(int i);
        case (i) 0: return tx0; 1: return tx1; default: return tx2; endcase
    endfunction
    function automatic logic get_busy(int i);
        case (i) 0: return busy0; 1: return busy1; default: return busy2; endcase
    endfunction
    function automatic logic get_ready(int i);
        case (i) 0: return if0.tx_ready; 1: return if1.tx_ready; default: return if2.tx_ready; endcase
    endfunction
    function automatic logic [2:0] get_level(int i);
        case (i) 0: return lvl0; 1: return lvl1; default: return lvl2; endcase
    endfunction

    // Reference frame: start 0, data LSB first, parity making the set of ones
    // odd/even, then stop bits (all remaining positions stay 1).
    function automatic logic [15:0] mkframe(int i, logic [7:0] w);
        logic [15:0] f;
        int k;
        int ones;
        f = '1;
        f[0] = 1'b0;
        k = 1;
        ones = 0;
        for (int d = 0; d < nbits(i); d++) begin
            f[k] = w[d];
            ones += int'(w[d]);
            k++;
        end
        if (pmode(i) == 1) f[k] = ((ones % 2) == 0);
        else if (pmode(i) == 2) f[k] = ((ones % 2) == 1);
        return f;
    endfunction

    logic [7:0] q0[$], q1[$], q2[$];

    function automatic void exp_push(int i, logic [7:0] w);
        case (i) 0: q0.push_back(w); 1: q1.push_back(w); default: q2.push_back(w); endcase
    endfunction
    function automatic logic [7:0] exp_pop(int i);
        case (i) 0: return q0.pop_front(); 1: return q1.pop_front(); default: return q2.pop_front(); endcase
    endfunction
    function automatic int exp_size(int i);
        case (i) 0: return q0.size(); 1: return q1.size(); default: return q2.size(); endcase
    endfunction
    function automatic void exp_clear(int i);
        case (i) 0: q0.delete(); 1: q1.delete(); default: q2.delete(); endcase
    endfunction

    int          act  [3];
    int          jj   [3];
    logic [15:0] fexp [3];
    logic        prevl[3];
    longint      stt  [3][16];
    int          stn  [3];

    // Line decoder: a falling edge from idle starts a frame; each bit is
    // sampled at its centre and compared with the next expected frame.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            logic l;
            l = get_line(i);
            if (reset) begin
                act[i] = 0;
                exp_clear(i);
                prevl[i] = 1'b1;
            end else begin
                if (act[i] == 0 && l == 1'b0 && prevl[i] == 1'b1) begin
                    act[i] = 1;
                    jj[i] = 0;
                    if (stn[i] < 16) begin
                        stt[i][stn[i]] = $time - 5;
                        stn[i]++;
                    end
                    check($sformatf("u%0d_frame_expected", i), exp_size(i) != 0, 1);
                    fexp[i] = (exp_size(i) != 0) ? mkframe(i, exp_pop(i)) : '1;
                end
                if (act[i] != 0) begin
                    if ((jj[i] % cdiv(i)) == cdiv(i) / 2)
                        check($sformatf("u%0d_bit%0d", i, jj[i] / cdiv(i)), l, fexp[i][jj[i] / cdiv(i)]);
                    jj[i]++;
                    if (jj[i] == flen(i) * cdiv(i)) act[i] = 0;
                end
                prevl[i] = l;
            end
        end
    end

    task automatic drive(input int i, input logic v, input logic [7:0] d);
        case (i)
            0: begin if0.tx_valid = v; if0.tx_data = d; end
            1: begin if1.tx_valid = v; if1.tx_data = d; end
            default: begin if2.tx_valid = v; if2.tx_data = d[6:0]; end
        endcase
    endtask

    // Leaves tx_valid high so consecutive calls form a continuous burst.
    task automatic send(input int i, input logic [7:0] w, output longint t_acc);
        int n;
        n = 0;
        @(negedge clk);
        drive(i, 1'b1, w);
        while (!get_ready(i) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("u%0d_accept_in_time", i), get_ready(i), 1);
        @(posedge clk);
        t_acc = $time;
        exp_push(i, w & wmask(i));
        #1;
    endtask

    task automatic release_valid(input int i);
        @(negedge clk);
        drive(i, 1'b0, 8'h00);
    endtask

    task automatic drain(input int i);
        int n;
        n = 0;
        while ((exp_size(i) != 0 || act[i] != 0 || get_busy(i)) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("u%0d_drain_in_time", i), n < 5000, 1);
        repeat (2) @(negedge clk);
        check($sformatf("u%0d_idle_line", i), get_line(i), 1);
    endtask

    task automatic wait_start(input int i, input int count);
        int n;
        n = 0;
        while (stn[i] < count && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("u%0d_start_seen", i), stn[i] >= count, 1);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        longint t;
        longint f;
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(i, 1'b0, 8'h00);
            act[i] = 0;
            jj[i] = 0;
            prevl[i] = 1'b1;
            stn[i] = 0;
        end

        // Reset state on all variants
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("u%0d_rst_tx", i), get_line(i), 1);
            check($sformatf("u%0d_rst_busy", i), get_busy(i), 0);
            check($sformatf("u%0d_rst_level", i), get_level(i), 0);
            check($sformatf("u%0d_rst_ready", i), get_ready(i), 1);
        end
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Basic 8N1 frame, latency and busy
        stn[0] = 0;
        send(0, 8'h48, t);
        release_valid(0);
        wait_start(0, 1);
        f = stt[0][0];
        check("u0_fall_latency", f, t + 20);
        #((f + 375) - $time);
        check("u0_busy_in_frame", busy0, 1);
        #((f + 405) - $time);
        check("u0_busy_after_frame", busy0, 0);
        drain(0);

        // Even parity back-to-back: 44-cycle frames
        stn[1] = 0;
        send(1, 8'h48, t);
        send(1, 8'h49, t);
        release_valid(1);
        drain(1);
        check("u1_frame_len", stt[1][1] - stt[1][0], 440);

        // 7 data bits, odd parity, 2 stop bits: 33-cycle frames
        stn[2] = 0;
        send(2, 8'h55, t);
        send(2, 8'($urandom), t);
        release_valid(2);
        drain(2);
        check("u2_frame_len", stt[2][1] - stt[2][0], 330);

        // Back-pressure: 6 words with tx_valid held
        stn[0] = 0;
        for (int k = 0; k < 6; k++) begin
            send(0, 8'h41 + 8'(k), t);
            if (k == 3) check("u0_ready_after_4", if0.tx_ready, 1);
            if (k == 4) check("u0_ready_after_5", if0.tx_ready, 0);
            if (k == 5) check("u0_6th_accept_time", t, stt[0][0] + 400);
        end
        release_valid(0);
        drain(0);
        check("u0_bp_frames", stn[0], 6);
        for (int k = 1; k < 6; k++)
            check($sformatf("u0_bp_gap%0d", k), stt[0][k] - stt[0][k-1], 400);

        // Push and pop on the same edge at the end of STOP
        stn[0] = 0;
        for (int k = 0; k < 4; k++) send(0, 8'($urandom), t);
        release_valid(0);
        wait_start(0, 1);
        f = stt[0][0];
        #((f + 384) - $time);
        check("u0_level_before_pushpop", lvl0, 3);
        send(0, 8'($urandom), t);
        check("u0_pushpop_time", t, f + 390);
        check("u0_level_after_pushpop", lvl0, 3);
        release_valid(0);
        drain(0);
        check("u0_pushpop_frames", stn[0], 5);

        // Randomized traffic on the parity variants
        for (int r = 0; r < 16; r++) begin
            int i;
            i = 1 + int'($urandom_range(0, 1));
            send(i, 8'($urandom), t);
            if ($urandom_range(0, 3) != 0) begin
                release_valid(i);
                repeat ($urandom_range(0, 60)) @(negedge clk);
            end
        end
        release_valid(1);
        release_valid(2);
        drain(1);
        drain(2);

        // Reset during DATA bit 3 with two words queued
        stn[0] = 0;
        send(0, 8'hF0, t);
        send(0, 8'h3C, t);
        send(0, 8'hC3, t);
        release_valid(0);
        wait_start(0, 1);
        f = stt[0][0];
        #((f + 183) - $time);
        check("u0_line_bit3_before_reset", tx0, 0);
        check("u0_level_before_reset", lvl0, 2);
        reset = 1'b1;
        #1;
        check("u0_reset_tx", tx0, 1);
        check("u0_reset_level", lvl0, 0);
        check("u0_reset_busy", busy0, 0);
        check("u0_reset_ready", if0.tx_ready, 1);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        stn[0] = 0;
        send(0, 8'hA5, t);
        release_valid(0);
        drain(0);
        check("u0_post_reset_frames", stn[0], 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
